// File: rtl/vga_pkg.sv
// Shared 640x480 @ 60 Hz timing constants and coordinate type for the VGA block.
package vga_pkg;

    localparam int unsigned CNT_W = 10;

    localparam int unsigned H_VISIBLE_DEF = 640;
    localparam int unsigned H_FRONT_DEF   = 16;
    localparam int unsigned H_SYNC_DEF    = 96;
    localparam int unsigned H_BACK_DEF    = 48;
    localparam int unsigned H_TOTAL_DEF   = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;

    localparam int unsigned V_VISIBLE_DEF = 480;
    localparam int unsigned V_FRONT_DEF   = 10;
    localparam int unsigned V_SYNC_DEF    = 2;
    localparam int unsigned V_BACK_DEF    = 33;
    localparam int unsigned V_TOTAL_DEF   = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

    typedef logic [CNT_W-1:0] coord_t;

endpackage

// File: rtl/vga_clk_div.sv
// Pixel-rate enable: tick is high for one system clock out of every CLK_DIV.
module vga_clk_div #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic CLK,
    input  logic RST_N,
    output logic tick
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;

    // Free-running divider 0..CLK_DIV-1; with CLK_DIV=1 it sits at 0 so tick is constant high.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            div_cnt <= '0;
        end else if (div_cnt == LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    assign tick = (div_cnt == LAST);

endmodule

// File: rtl/vga.sv
// VGA timing generator: pixel/line counters with registered sync and blank decode.
module vga
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned H_VISIBLE = H_VISIBLE_DEF,
    parameter int unsigned H_FRONT   = H_FRONT_DEF,
    parameter int unsigned H_SYNC    = H_SYNC_DEF,
    parameter int unsigned H_BACK    = H_BACK_DEF,
    parameter int unsigned V_VISIBLE = V_VISIBLE_DEF,
    parameter int unsigned V_FRONT   = V_FRONT_DEF,
    parameter int unsigned V_SYNC    = V_SYNC_DEF,
    parameter int unsigned V_BACK    = V_BACK_DEF
) (
    input  logic             CLK,
    input  logic             RST_N,
    output logic             HS,
    output logic             VS,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             blank
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam coord_t H_LAST     = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST     = coord_t'(V_TOTAL - 1);
    localparam coord_t H_VIS_END  = coord_t'(H_VISIBLE);
    localparam coord_t V_VIS_END  = coord_t'(V_VISIBLE);
    localparam coord_t H_SYNC_BEG = coord_t'(H_VISIBLE + H_FRONT);
    localparam coord_t H_SYNC_END = coord_t'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam coord_t V_SYNC_BEG = coord_t'(V_VISIBLE + V_FRONT);
    localparam coord_t V_SYNC_END = coord_t'(V_VISIBLE + V_FRONT + V_SYNC);

    logic   tick;
    coord_t x_nxt;
    coord_t y_nxt;

    vga_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .CLK   (CLK),
        .RST_N (RST_N),
        .tick  (tick)
    );

    // Next raster position: advance one pixel per tick, wrapping line then frame.
    always_comb begin
        x_nxt = x;
        y_nxt = y;
        if (tick) begin
            if (x == H_LAST) begin
                x_nxt = '0;
                y_nxt = (y == V_LAST) ? '0 : y + coord_t'(1);
            end else begin
                x_nxt = x + coord_t'(1);
            end
        end
    end

    // Counters plus sync/blank decoded from the next position, so flags line up with x/y.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            x     <= '0;
            y     <= '0;
            HS    <= 1'b1;
            VS    <= 1'b1;
            blank <= 1'b0;
        end else begin
            x     <= x_nxt;
            y     <= y_nxt;
            blank <= (x_nxt >= H_VIS_END) || (y_nxt >= V_VIS_END);
            HS    <= !((x_nxt >= H_SYNC_BEG) && (x_nxt < H_SYNC_END));
            VS    <= !((y_nxt >= V_SYNC_BEG) && (y_nxt < V_SYNC_END));
        end
    end

endmodule

// File: tb/tb_vga.sv
// Self-checking bench for vga: three geometries checked every clock against a raster model.
module tb_vga;

    logic CLK;
    logic RST_N;

    logic       hs_a, vs_a, blank_a;
    logic [9:0] x_a, y_a;
    logic       hs_b, vs_b, blank_b;
    logic [9:0] x_b, y_b;
    logic       hs_c, vs_c, blank_c;
    logic [9:0] x_c, y_c;

    int unsigned checks;
    int unsigned errors;
    int unsigned n;

    typedef struct {
        int unsigned x;
        int unsigned y;
        bit          hs;
        bit          vs;
        bit          blank;
    } vstate_t;

    // Full 640x480 timing at the default divide of 4.
    vga #(
        .CLK_DIV (4)
    ) dut_a (
        .CLK (CLK), .RST_N (RST_N), .HS (hs_a), .VS (vs_a),
        .x (x_a), .y (y_a), .blank (blank_a)
    );

    // Full timing, one pixel per clock.
    vga #(
        .CLK_DIV (1)
    ) dut_b (
        .CLK (CLK), .RST_N (RST_N), .HS (hs_b), .VS (vs_b),
        .x (x_b), .y (y_b), .blank (blank_b)
    );

    // Tiny raster (15 x 13) so whole frames and vertical sync fit in a short run.
    vga #(
        .CLK_DIV   (3),
        .H_VISIBLE (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (2),
        .V_VISIBLE (6), .V_FRONT (2), .V_SYNC (2), .V_BACK (3)
    ) dut_c (
        .CLK (CLK), .RST_N (RST_N), .HS (hs_c), .VS (vs_c),
        .x (x_c), .y (y_c), .blank (blank_c)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Raster position after n rising edges since reset release, from tick count alone.
    function automatic vstate_t model(input int unsigned edges, input int unsigned div,
                                      input int unsigned hv, input int unsigned hf,
                                      input int unsigned hsw, input int unsigned hb,
                                      input int unsigned vv, input int unsigned vf,
                                      input int unsigned vsw, input int unsigned vb);
        vstate_t     s;
        int unsigned ht, vt, pos;
        ht      = hv + hf + hsw + hb;
        vt      = vv + vf + vsw + vb;
        pos     = (edges / div) % (ht * vt);
        s.x     = pos % ht;
        s.y     = pos / ht;
        s.blank = (s.x >= hv) || (s.y >= vv);
        s.hs    = !((s.x >= hv + hf) && (s.x < hv + hf + hsw));
        s.vs    = !((s.y >= vv + vf) && (s.y < vv + vf + vsw));
        return s;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d (edge %0d)", tag, obs, exp, n);
        end
    endtask

    task automatic check_all(input int unsigned edges);
        vstate_t e;
        e = model(edges, 4, 640, 16, 96, 48, 480, 10, 2, 33);
        check("a.x", 32'(x_a), e.x);
        check("a.y", 32'(y_a), e.y);
        check("a.hs", 32'(hs_a), 32'(e.hs));
        check("a.vs", 32'(vs_a), 32'(e.vs));
        check("a.blank", 32'(blank_a), 32'(e.blank));
        e = model(edges, 1, 640, 16, 96, 48, 480, 10, 2, 33);
        check("b.x", 32'(x_b), e.x);
        check("b.y", 32'(y_b), e.y);
        check("b.hs", 32'(hs_b), 32'(e.hs));
        check("b.vs", 32'(vs_b), 32'(e.vs));
        check("b.blank", 32'(blank_b), 32'(e.blank));
        e = model(edges, 3, 8, 2, 3, 2, 6, 2, 2, 3);
        check("c.x", 32'(x_c), e.x);
        check("c.y", 32'(y_c), e.y);
        check("c.hs", 32'(hs_c), 32'(e.hs));
        check("c.vs", 32'(vs_c), 32'(e.vs));
        check("c.blank", 32'(blank_c), 32'(e.blank));
    endtask

    initial begin
        int unsigned run_len;
        int unsigned stop_at;
        int unsigned hold;
        int unsigned hs_falls;
        int unsigned vs_falls;
        logic        hs_prev;
        logic        vs_prev;

        checks   = 0;
        errors   = 0;
        n        = 0;
        hs_falls = 0;
        vs_falls = 0;
        hs_prev  = 1'b1;
        vs_prev  = 1'b1;

        // Reset held with the clock running: outputs stay at reset values.
        RST_N = 1'b0;
        hold  = 10 + $urandom_range(0, 5);
        for (int i = 0; i < int'(hold); i++) begin
            @(posedge CLK);
            #1 check_all(0);
        end
        RST_N = 1'b1;

        // First run: covers two full lines at divide 4, many at divide 1, and
        // more than one small frame; small-frame sync pulses counted over frame one.
        run_len = 6400 + $urandom_range(0, 1500);
        for (int i = 0; i < int'(run_len); i++) begin
            @(posedge CLK);
            n++;
            #1 check_all(n);
            if (n <= 585) begin
                if (hs_prev && !hs_c) hs_falls++;
                if (vs_prev && !vs_c) vs_falls++;
            end
            hs_prev = hs_c;
            vs_prev = vs_c;
        end
        check("c.hs_pulses_per_frame", hs_falls, 13);
        check("c.vs_pulses_per_frame", vs_falls, 1);

        // Mid-frame asynchronous reset, asserted between clock edges.
        stop_at = n + 585 + $urandom_range(0, 584);
        for (int i = 0; i < 2000 && n < stop_at; i++) begin
            @(posedge CLK);
            n++;
            #1 check_all(n);
        end
        #2 RST_N = 1'b0;
        #1 n = 0;
        check_all(0);
        hold = 1 + $urandom_range(0, 4);
        for (int i = 0; i < int'(hold); i++) begin
            @(posedge CLK);
            #1 check_all(0);
        end
        RST_N = 1'b1;

        // Restart from (0,0) after release.
        run_len = 3300 + $urandom_range(0, 500);
        for (int i = 0; i < int'(run_len); i++) begin
            @(posedge CLK);
            n++;
            #1 check_all(n);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
